// File: rtl/cla_multiword_add_seq_pkg.sv
// Shared definitions for the multi-word CLA adder: slice width, FSM encoding
// and the 4-bit carry-lookahead expansion used inside the 16-bit slice.
package cla_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Carries c0..c4 of a 4-bit group, each written as a flat sum of products
  function automatic logic [4:0] lookahead4(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & c0);
    return c;
  endfunction

endpackage

// File: rtl/cla_multiword_add_seq_if.sv
// Operand/result handshake bundle of the multi-word adder.
interface cla_multiword_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/cla_multiword_add_seq_cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups plus a group-level
// lookahead unit, so no carry ripples through more than one group.
module CLA_16_bit_lookahead
  import cla_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, pg;
  logic [4:0]  cg;
  logic [4:0]  tmp;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    g   = a_i & b_i;
    p   = a_i ^ b_i;
    gg  = '0;
    pg  = '0;
    c   = '0;
    tmp = '0;
    for (int j = 0; j < 4; j++) begin
      tmp   = lookahead4(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gg[j] = tmp[4];
      pg[j] = &p[4*j +: 4];
    end
    cg = lookahead4(gg, pg, cin_i);
    for (int j = 0; j < 4; j++) begin
      tmp        = lookahead4(g[4*j +: 4], p[4*j +: 4], cg[j]);
      c[4*j +: 4] = tmp[3:0];
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = cg[4];

endmodule

// File: rtl/cla_multiword_add_seq.sv
// Multi-cycle 16*WORDS-bit add/sub: one 16-bit CLA slice is reused for every
// limb, least significant first, with the inter-limb carry held in a flop.
module cla_multiword_add_seq
  import cla_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cla_multiword_add_seq_if.slave   bus
);

  localparam int W  = SLICE_W * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[SLICE_W*int'(k_q) +: SLICE_W];
  assign slice_b = b_q[SLICE_W*int'(k_q) +: SLICE_W];

  CLA_16_bit_lookahead u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1: invert B once here, seed the carry with 1
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub ? 1'b1 : bus.in_cin;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[SLICE_W*int'(k_q) +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of the order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;
  // Signed overflow: operands agree in sign but the result does not
  assign bus.out_ovf   = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// Bench for cla_multiword_add_seq: directed corner cases on WORDS=4, then
// randomized traffic with stalls on WORDS=4, 3 and 1 against an arithmetic model.
module tb_cla_multiword_add_seq;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  cla_multiword_add_seq_if #(.WORDS(4)) if4 ();
  cla_multiword_add_seq_if #(.WORDS(3)) if3 ();
  cla_multiword_add_seq_if #(.WORDS(1)) if1 ();

  cla_multiword_add_seq #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  cla_multiword_add_seq #(.WORDS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  cla_multiword_add_seq #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum}: unsigned W+1-bit result plus signed range test
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [64:0] mask, ua, ub, full;
    logic signed [66:0] sa, sb, sr, lim;
    logic cout, ovf;
    mask = (65'd1 << w) - 65'd1;
    ua   = {1'b0, a} & mask;
    ub   = {1'b0, b} & mask;
    sa   = $signed({2'b00, ua});
    sb   = $signed({2'b00, ub});
    if (ua[w-1]) sa = sa - (67'sd1 <<< w);
    if (ub[w-1]) sb = sb - (67'sd1 <<< w);
    if (sub) begin
      full = (ua - ub) & mask;
      cout = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + {64'd0, cin};
      cout = full[w];
      full = full & mask;
      sr   = sa + sb + (cin ? 67'sd1 : 67'sd0);
    end
    lim = 67'sd1 <<< (w - 1);
    ovf = (sr >= lim) || (sr < -lim);
    return {ovf, cout, full[63:0]};
  endfunction

  function automatic logic [63:0] rand_operand(input int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return m;
      2:       return m >> 1;
      3:       return (m >> 1) + 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub);
    case (sel)
      0: begin if4.in_valid = v; if4.in_a = a;        if4.in_b = b;        if4.in_cin = cin; if4.in_sub = sub; end
      1: begin if3.in_valid = v; if3.in_a = a[47:0];  if3.in_b = b[47:0];  if3.in_cin = cin; if3.in_sub = sub; end
      default: begin if1.in_valid = v; if1.in_a = a[15:0]; if1.in_b = b[15:0]; if1.in_cin = cin; if1.in_sub = sub; end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic r);
    case (sel)
      0:       if4.out_ready = r;
      1:       if3.out_ready = r;
      default: if1.out_ready = r;
    endcase
  endtask

  task automatic sample(input int sel, output logic irdy, output logic ovld,
                        output logic [63:0] sum, output logic cout, output logic ovf);
    case (sel)
      0: begin irdy = if4.in_ready; ovld = if4.out_valid; sum = if4.out_sum;        cout = if4.out_cout; ovf = if4.out_ovf; end
      1: begin irdy = if3.in_ready; ovld = if3.out_valid; sum = 64'(if3.out_sum);   cout = if3.out_cout; ovf = if3.out_ovf; end
      default: begin irdy = if1.in_ready; ovld = if1.out_valid; sum = 64'(if1.out_sum); cout = if1.out_cout; ovf = if1.out_ovf; end
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(if4.in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(if4.out_valid), 64'd0);
    check({tag, "_out_sum"},   if4.out_sum,        64'd0);
    check({tag, "_out_cout"},  64'(if4.out_cout),  64'd0);
    check({tag, "_out_ovf"},   64'(if4.out_ovf),   64'd0);
    check({tag, "_busy"},      64'(if4.busy),      64'd0);
  endtask

  // Waits for out_valid on the WORDS=4 instance; returns negedges counted since the accept edge
  task automatic wait_valid4(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if4.out_valid && cyc < 50);
  endtask

  task automatic run_directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic cin, input logic sub, input logic [63:0] esum,
                              input logic ecout, input logic eovf);
    int cyc;
    @(posedge clk); #1;
    drive_in(0, 1'b1, a, b, cin, sub);
    set_ordy(0, 1'b1);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(if4.in_ready), 64'd1);
    @(posedge clk); #1;
    drive_in(0, 1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid4(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd5);
    check({tag, "_sum"},  if4.out_sum,       esum);
    check({tag, "_cout"}, 64'(if4.out_cout), 64'(ecout));
    check({tag, "_ovf"},  64'(if4.out_ovf),  64'(eovf));
    check({tag, "_busy"}, 64'(if4.busy),     64'd1);
    @(negedge clk);
    check({tag, "_consumed"}, 64'(if4.out_valid), 64'd0);
  endtask

  task automatic run_random(input int sel, input int w, input int nops);
    logic [65:0] exp_q[$];
    logic [65:0] e;
    logic [63:0] a, b, sum;
    logic        cin, sub, v, r, irdy, ovld, cout, ovf;
    int accepted = 0;
    int consumed = 0;
    int cyc      = 0;
    while (consumed < nops && cyc < nops * 40) begin
      @(posedge clk); #1;
      v   = (accepted < nops) && ($urandom_range(3) != 0);
      a   = rand_operand(w);
      b   = rand_operand(w);
      cin = 1'($urandom_range(1));
      sub = 1'($urandom_range(1));
      r   = ($urandom_range(2) != 0);
      drive_in(sel, v, a, b, cin, sub);
      set_ordy(sel, r);
      @(negedge clk);
      sample(sel, irdy, ovld, sum, cout, ovf);
      if (v && irdy) begin
        exp_q.push_back(model(w, a, b, cin, sub));
        accepted++;
      end
      if (ovld && r) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rand_w%0d_spurious_result", w), 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rand_w%0d_sum", w),  sum,        e[63:0]);
          check($sformatf("rand_w%0d_cout", w), 64'(cout),  64'(e[64]));
          check($sformatf("rand_w%0d_ovf", w),  64'(ovf),   64'(e[65]));
        end
        consumed++;
      end
      cyc++;
    end
    check($sformatf("rand_w%0d_completed", w), 64'(consumed), 64'(nops));
    check($sformatf("rand_w%0d_leftover", w), 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    drive_in(sel, 1'b0, '0, '0, 1'b0, 1'b0);
    set_ordy(sel, 1'b0);
  endtask

  initial begin
    logic [65:0] e;
    logic [63:0] a, b, hold_sum;
    int cyc;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive_in(s, 1'b0, '0, '0, 1'b0, 1'b0);
      set_ordy(s, 1'b0);
    end
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Carry ripples across every limb boundary
    run_directed("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run_directed("sub_borrow", 64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_directed("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    // cin is ignored for subtraction
    run_directed("sub_cin_ignored", 64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0);
    run_directed("add_cin", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);

    // Backpressure: result holds while in_valid keeps offering new operands
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'hFEDC_BA98_7654_3210;
    e = model(64, a, b, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b1, a, b, 1'b1, 1'b0);
    set_ordy(0, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b1, rand_operand(64), rand_operand(64), 1'b0, 1'b1);
    wait_valid4(cyc);
    check("bp_latency", 64'(cyc), 64'd5);
    hold_sum = e[63:0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_in(0, 1'b1, rand_operand(64), rand_operand(64), 1'($urandom_range(1)), 1'($urandom_range(1)));
      @(negedge clk);
      check($sformatf("bp_hold%0d_sum", i),   if4.out_sum,        hold_sum);
      check($sformatf("bp_hold%0d_cout", i),  64'(if4.out_cout),  64'(e[64]));
      check($sformatf("bp_hold%0d_ovf", i),   64'(if4.out_ovf),   64'(e[65]));
      check($sformatf("bp_hold%0d_valid", i), 64'(if4.out_valid), 64'd1);
      check($sformatf("bp_hold%0d_ready", i), 64'(if4.in_ready),  64'd0);
    end
    a = 64'h8000_0000_0000_0001;
    b = 64'h0000_0000_0000_0005;
    e = model(64, a, b, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_in(0, 1'b1, a, b, 1'b0, 1'b1);
    set_ordy(0, 1'b1);
    @(negedge clk);
    check("bp_release_valid", 64'(if4.out_valid), 64'd1);
    @(negedge clk);
    check("bp_idle_valid", 64'(if4.out_valid), 64'd0);
    check("bp_idle_ready", 64'(if4.in_ready),  64'd1);
    @(posedge clk); #1;
    drive_in(0, 1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid4(cyc);
    check("bp_next_latency", 64'(cyc), 64'd5);
    check("bp_next_sum",  if4.out_sum,       e[63:0]);
    check("bp_next_cout", 64'(if4.out_cout), 64'(e[64]));
    check("bp_next_ovf",  64'(if4.out_ovf),  64'(e[65]));
    @(negedge clk);

    // Reset while limb 2 is in flight
    @(posedge clk); #1;
    drive_in(0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    check("mid_run_busy", 64'(if4.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_run_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_directed("post_reset", 64'h1234, 64'h0001, 1'b0, 1'b0, 64'h1235, 1'b0, 1'b0);

    run_random(0, 64, 700);
    run_random(1, 48, 650);
    run_random(2, 16, 650);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
